// File: rtl/tlk2711_tx_framer_if.sv
// Request, DMA read-stream and TLK2711 transmit-pin bundle between the TX command stage and the framer.
// The framer uses the slave modport; the upstream side (or a bench) uses master.
interface tlk2711_tx_framer_if;
    logic        i_send_start;
    logic [31:0] i_packet_body;
    logic [9:0]  i_packet_tail;
    logic [63:0] i_axis_tdata;
    logic        i_axis_tvalid;
    logic        o_axis_tready;
    logic [15:0] o_txd;
    logic        o_tkmsb;
    logic        o_tklsb;
    logic        o_tx_en;
    logic        o_busy;
    logic        o_tx_done;
    logic        o_underflow;
    logic        o_start_err;

    modport master (
        output i_send_start, i_packet_body, i_packet_tail, i_axis_tdata, i_axis_tvalid,
        input  o_axis_tready, o_txd, o_tkmsb, o_tklsb, o_tx_en, o_busy, o_tx_done,
               o_underflow, o_start_err
    );

    modport slave (
        input  i_send_start, i_packet_body, i_packet_tail, i_axis_tdata, i_axis_tvalid,
        output o_axis_tready, o_txd, o_tkmsb, o_tklsb, o_tx_en, o_busy, o_tx_done,
               o_underflow, o_start_err
    );
endinterface

// File: rtl/tlk2711_tx_framer.sv
// Serialises one request plus its 64-bit DMA beats into SOF/HDR0/HDR1/payload/TAIL/CHK/EOF
// 16-bit words for the TLK2711, with idle words between frames and as mid-payload fill.
module tlk2711_tx_framer #(
    parameter logic [15:0] IDLE_WORD = 16'h50BC,
    parameter logic [15:0] SOF_WORD  = 16'h50FB,
    parameter logic [15:0] EOF_WORD  = 16'h50FD
) (
    input  logic               i_clk,
    input  logic               i_soft_rst_n,
    tlk2711_tx_framer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_HDR0, S_HDR1, S_PAY, S_TAIL, S_CHK, S_EOF
    } state_t;

    // The state names the word currently on o_txd; the next word is computed from it.
    state_t      r_state, w_state_nx;
    logic [31:0] r_body;
    logic [9:0]  r_tail;
    logic [30:0] r_words_left, w_words_left_nx;
    logic [30:0] r_beats_left, w_beats_left_nx;
    logic [63:0] r_hold, w_hold_nx;
    logic        r_hold_v, w_hold_v_nx;
    logic [1:0]  r_ptr, w_ptr_nx;
    logic [15:0] r_chk, w_chk_nx;
    logic [15:0] r_txd, w_txd_nx;
    logic        r_is_k, w_is_k_nx;
    logic        r_tready, w_tready_nx;
    logic        r_busy, r_tx_done, r_underflow, r_start_err, r_tx_en;
    logic        w_tx_done_nx, w_underflow_nx;
    logic        w_fire;
    logic [30:0] w_words;

    function automatic logic [15:0] lane_sel(input logic [63:0] beat, input logic [1:0] lane);
        logic [15:0] w;
        case (lane)
            2'd0:    w = beat[15:0];
            2'd1:    w = beat[31:16];
            2'd2:    w = beat[47:32];
            2'd3:    w = beat[63:48];
            default: w = beat[15:0];
        endcase
        return w;
    endfunction

    // Next-word, buffer and checksum computation for the coming cycle.
    always_comb begin
        w_fire          = r_tready & bus.i_axis_tvalid;
        w_words         = bus.i_packet_body[31:1];
        w_state_nx      = r_state;
        w_txd_nx        = IDLE_WORD;
        w_is_k_nx       = 1'b1;
        w_words_left_nx = r_words_left;
        w_beats_left_nx = w_fire ? (r_beats_left - 31'd1) : r_beats_left;
        w_hold_nx       = r_hold;
        w_hold_v_nx     = r_hold_v;
        w_ptr_nx        = r_ptr;
        w_chk_nx        = r_chk;
        w_tx_done_nx    = 1'b0;
        w_underflow_nx  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_send_start) begin
                    w_state_nx      = S_SOF;
                    w_txd_nx        = SOF_WORD;
                    w_words_left_nx = w_words;
                    w_beats_left_nx = {2'b00, w_words[30:2]} + {30'd0, |w_words[1:0]};
                    w_hold_v_nx     = 1'b0;
                    w_ptr_nx        = 2'd0;
                    w_chk_nx        = 16'd0;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_SOF: begin
                w_state_nx = S_HDR0;
                w_txd_nx   = r_body[15:0];
                w_is_k_nx  = 1'b0;
                w_chk_nx   = r_chk + r_body[15:0];
            end
            S_HDR0: begin
                w_state_nx = S_HDR1;
                w_txd_nx   = r_body[31:16];
                w_is_k_nx  = 1'b0;
                w_chk_nx   = r_chk + r_body[31:16];
            end
            S_HDR1, S_PAY: begin
                if (r_words_left == 31'd0) begin
                    w_state_nx = S_TAIL;
                    w_txd_nx   = {6'd0, r_tail};
                    w_is_k_nx  = 1'b0;
                    w_chk_nx   = r_chk + {6'd0, r_tail};
                end else if (r_hold_v) begin
                    w_state_nx      = S_PAY;
                    w_txd_nx        = lane_sel(r_hold, r_ptr);
                    w_is_k_nx       = 1'b0;
                    w_chk_nx        = r_chk + lane_sel(r_hold, r_ptr);
                    w_words_left_nx = r_words_left - 31'd1;
                    if ((r_ptr == 2'd3) || (r_words_left == 31'd1)) begin
                        w_hold_v_nx = 1'b0;
                    end else begin
                        w_ptr_nx = r_ptr + 2'd1;
                    end
                    if (w_fire) begin
                        w_hold_nx   = bus.i_axis_tdata;
                        w_hold_v_nx = 1'b1;
                        w_ptr_nx    = 2'd0;
                    end else begin
                        w_hold_nx = r_hold;
                    end
                end else if (w_fire) begin
                    // Empty register: lane 0 goes straight out, the rest is held.
                    w_state_nx      = S_PAY;
                    w_txd_nx        = bus.i_axis_tdata[15:0];
                    w_is_k_nx       = 1'b0;
                    w_chk_nx        = r_chk + bus.i_axis_tdata[15:0];
                    w_words_left_nx = r_words_left - 31'd1;
                    w_hold_nx       = bus.i_axis_tdata;
                    w_hold_v_nx     = (r_words_left > 31'd1);
                    w_ptr_nx        = 2'd1;
                end else begin
                    w_state_nx     = S_PAY;
                    w_underflow_nx = 1'b1;
                end
            end
            S_TAIL: begin
                w_state_nx = S_CHK;
                w_txd_nx   = r_chk;
                w_is_k_nx  = 1'b0;
            end
            S_CHK: begin
                w_state_nx   = S_EOF;
                w_txd_nx     = EOF_WORD;
                w_tx_done_nx = 1'b1;
            end
            S_EOF: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
        w_tready_nx = ((w_state_nx == S_HDR1) || (w_state_nx == S_PAY)) &&
                      (w_beats_left_nx != 31'd0) && (!w_hold_v_nx || (w_ptr_nx == 2'd3));
    end

    // Frame state, holding register and registered pin outputs.
    always_ff @(posedge i_clk) begin
        if (!i_soft_rst_n) begin
            r_state      <= S_IDLE;
            r_body       <= 32'd0;
            r_tail       <= 10'd0;
            r_words_left <= 31'd0;
            r_beats_left <= 31'd0;
            r_hold       <= 64'd0;
            r_hold_v     <= 1'b0;
            r_ptr        <= 2'd0;
            r_chk        <= 16'd0;
            r_txd        <= IDLE_WORD;
            r_is_k       <= 1'b1;
            r_tready     <= 1'b0;
            r_busy       <= 1'b0;
            r_tx_done    <= 1'b0;
            r_underflow  <= 1'b0;
            r_start_err  <= 1'b0;
            r_tx_en      <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_words_left <= w_words_left_nx;
            r_beats_left <= w_beats_left_nx;
            r_hold       <= w_hold_nx;
            r_hold_v     <= w_hold_v_nx;
            r_ptr        <= w_ptr_nx;
            r_chk        <= w_chk_nx;
            r_txd        <= w_txd_nx;
            r_is_k       <= w_is_k_nx;
            r_tready     <= w_tready_nx;
            r_busy       <= (w_state_nx != S_IDLE);
            r_tx_done    <= w_tx_done_nx;
            r_underflow  <= w_underflow_nx;
            r_start_err  <= bus.i_send_start && (r_state != S_IDLE);
            r_tx_en      <= 1'b1;
            if ((r_state == S_IDLE) && bus.i_send_start) begin
                r_body <= bus.i_packet_body;
                r_tail <= bus.i_packet_tail;
            end else begin
                r_body <= r_body;
                r_tail <= r_tail;
            end
        end
    end

    assign bus.o_axis_tready = r_tready;
    assign bus.o_txd         = r_txd;
    assign bus.o_tklsb       = r_is_k;
    assign bus.o_tkmsb       = 1'b0;
    assign bus.o_tx_en       = r_tx_en;
    assign bus.o_busy        = r_busy;
    assign bus.o_tx_done     = r_tx_done;
    assign bus.o_underflow   = r_underflow;
    assign bus.o_start_err   = r_start_err;
endmodule

// File: tb/tb_tlk2711_tx_framer.sv
// Directed bench for tlk2711_tx_framer: expected frame words are queued when a request is
// issued and compared word by word while o_busy is high.
module tb_tlk2711_tx_framer;
    logic clk = 1'b0;
    logic rst_n;

    tlk2711_tx_framer_if bus ();

    tlk2711_tx_framer dut (
        .i_clk        (clk),
        .i_soft_rst_n (rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_fires  = 0;
    int          n_serr   = 0;
    int          n_uf     = 0;
    logic [19:0] exp_q[$];
    logic [63:0] beats[$];
    logic [15:0] chk_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] item(input logic [15:0] w, input logic k, input logic uf,
                                         input logic done);
        return {w, 1'b0, k, uf, done};
    endfunction

    // Queue one frame: payload taken from beats, fill_cnt idle words before payload word fill_at.
    task automatic push_frame(input logic [31:0] body, input logic [9:0] tail, input int fill_at,
                              input int fill_cnt, output logic [15:0] sum);
        logic [63:0] b;
        logic [15:0] w;
        int          nw;
        nw  = int'(body[31:1]);
        sum = body[15:0] + body[31:16];
        exp_q.push_back(item(16'h50FB, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(item(body[15:0], 1'b0, 1'b0, 1'b0));
        exp_q.push_back(item(body[31:16], 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < nw; i++) begin
            if (i == fill_at) begin
                for (int f = 0; f < fill_cnt; f++) exp_q.push_back(item(16'h50BC, 1'b1, 1'b1, 1'b0));
            end
            b   = beats[i / 4];
            w   = b[16 * (i % 4) +: 16];
            sum = sum + w;
            exp_q.push_back(item(w, 1'b0, 1'b0, 1'b0));
        end
        sum = sum + {6'd0, tail};
        exp_q.push_back(item({6'd0, tail}, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(item(sum, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(item(16'h50FD, 1'b1, 1'b0, 1'b1));
    endtask

    task automatic send_start(input logic [31:0] body, input logic [9:0] tail);
        @(posedge clk); #1;
        bus.i_send_start  = 1'b1;
        bus.i_packet_body = body;
        bus.i_packet_tail = tail;
        @(posedge clk); #1;
        bus.i_send_start  = 1'b0;
    endtask

    // Offer each queued beat until accepted; after the last one keep tvalid high with junk.
    task automatic drive_stream(input int gap_after_first);
        logic ok;
        for (int k = 0; k < beats.size(); k++) begin
            if (k == 1 && gap_after_first > 0) begin
                bus.i_axis_tvalid = 1'b0;
                repeat (gap_after_first) begin @(posedge clk); #1; end
            end
            bus.i_axis_tdata  = beats[k];
            bus.i_axis_tvalid = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 64 && !ok; c++) begin
                @(negedge clk);
                ok = bus.o_axis_tready && bus.i_axis_tvalid;
            end
            check("beat_accepted", 32'(ok), 32'd1);
            @(posedge clk); #1;
        end
        bus.i_axis_tdata  = 64'hDEAD_BEEF_CAFE_F00D;
        bus.i_axis_tvalid = 1'b1;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            seen = bus.o_tx_done;
        end
        check("tx_done_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        bus.i_axis_tvalid = 1'b0;
        @(negedge clk);
        check("frame_words_left", 32'(exp_q.size()), 32'd0);
        check("busy_after_frame", 32'(bus.o_busy), 32'd0);
    endtask

    // Word-by-word comparison while a frame is in progress, plus event counters.
    always @(negedge clk) begin
        if (bus.o_axis_tready === 1'b1 && bus.i_axis_tvalid === 1'b1) n_fires++;
        if (bus.o_start_err === 1'b1) n_serr++;
        if (bus.o_underflow === 1'b1) n_uf++;
        if (bus.o_busy === 1'b1) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_errors++;
                $error("FAIL extra_word: observed txd %h expected no frame word", bus.o_txd);
            end
            if (exp_q.size() > 0) begin
                check("frame_word",
                      32'({bus.o_txd, bus.o_tkmsb, bus.o_tklsb, bus.o_underflow, bus.o_tx_done}),
                      32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        rst_n             = 1'b0;
        bus.i_send_start  = 1'b0;
        bus.i_packet_body = 32'd0;
        bus.i_packet_tail = 10'd0;
        bus.i_axis_tdata  = 64'd0;
        bus.i_axis_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txd", 32'(bus.o_txd), 32'h0000_50BC);
        check("rst_tk", 32'({bus.o_tkmsb, bus.o_tklsb}), 32'd1);
        check("rst_tx_en", 32'(bus.o_tx_en), 32'd0);
        check("rst_tready", 32'(bus.o_axis_tready), 32'd0);
        check("rst_busy_pulses",
              32'({bus.o_busy, bus.o_tx_done, bus.o_underflow, bus.o_start_err}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("tx_en_after_release", 32'(bus.o_tx_en), 32'd1);

        // Single-beat frame, junk offered afterwards must not be taken.
        beats = '{64'h0004_0003_0002_0001};
        push_frame(32'd8, 10'h005, -1, 0, chk_model);
        n_fires = 0;
        send_start(32'd8, 10'h005);
        drive_stream(0);
        wait_done();
        check("t1_beats", 32'(n_fires), 32'd1);

        // Empty payload: tready never rises.
        beats = {};
        push_frame(32'd0, 10'h3FF, -1, 0, chk_model);
        n_fires = 0;
        send_start(32'd0, 10'h3FF);
        drive_stream(0);
        wait_done();
        check("t2_beats", 32'(n_fires), 32'd0);

        // Five words: second beat contributes only lane 0.
        beats = '{64'h1004_1003_1002_1001, 64'h2004_2003_2002_2001};
        push_frame(32'd10, 10'h0A5, -1, 0, chk_model);
        n_fires = 0;
        send_start(32'd10, 10'h0A5);
        drive_stream(0);
        wait_done();
        check("t3_beats", 32'(n_fires), 32'd2);

        // Stream gap mid-payload: two fills, excluded from CHK.
        beats = '{64'hA004_A003_A002_A001, 64'hB004_B003_B002_B001};
        push_frame(32'd16, 10'h133, 4, 2, chk_model);
        n_fires = 0;
        n_uf    = 0;
        send_start(32'd16, 10'h133);
        drive_stream(5);
        wait_done();
        check("t4_beats", 32'(n_fires), 32'd2);
        check("t4_underflows", 32'(n_uf), 32'd2);

        // Start during payload is dropped and flagged once.
        beats = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
        push_frame(32'd16, 10'h2C1, -1, 0, chk_model);
        n_serr = 0;
        send_start(32'd16, 10'h2C1);
        drive_stream(0);
        send_start(32'h0000_0040, 10'h001);
        wait_done();
        repeat (20) @(negedge clk);
        check("t5_start_err", 32'(n_serr), 32'd1);
        check("t5_no_second_frame", 32'(bus.o_busy), 32'd0);

        // Reset in the middle of payload, then a clean frame.
        beats = '{64'h1111_2222_3333_4444};
        push_frame(32'd8, 10'h007, -1, 0, chk_model);
        send_start(32'd8, 10'h007);
        bus.i_axis_tdata  = beats[0];
        bus.i_axis_tvalid = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_txd", 32'(bus.o_txd), 32'h0000_50BC);
        check("t6_rst_busy", 32'(bus.o_busy), 32'd0);
        check("t6_rst_tready", 32'(bus.o_axis_tready), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n             = 1'b1;
        bus.i_axis_tvalid = 1'b0;
        beats = '{64'h000D_000C_000B_000A};
        push_frame(32'd8, 10'h002, -1, 0, chk_model);
        n_fires = 0;
        send_start(32'd8, 10'h002);
        drive_stream(0);
        wait_done();
        check("t6_beats", 32'(n_fires), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
